// File: rtl/calc_pkg.sv
// Shared encodings for the multi-cycle calc stage: opcodes, operand-source selects, FSM states.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_CONST = 2'd1;
  localparam logic [1:0] SRCA_AQ    = 2'd2;
  localparam logic [1:0] SRCA_IMM   = 2'd3;

  localparam logic [1:0] SRCB_BQ    = 2'd0;
  localparam logic [1:0] SRCB_CONST = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_ZERO  = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;

endpackage

// File: rtl/seq_mul.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// done is high during the final step; product is the value that step produces.
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q, acc, acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count;

  always_comb begin
    acc_next = acc;
    if (mplier_q[0]) acc_next = acc + mcand_q;
  end

  assign done    = (count == CW'(1));
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc      <= '0;
      count    <= '0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, mcand};
      mplier_q <= mplier;
      acc      <= '0;
      count    <= CW'(WIDTH);
    end else if (count != '0) begin
      acc      <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count    <= count - 1'b1;
    end
  end

endmodule

// File: rtl/calc_stage_mc.sv
// Multi-cycle execute stage: operand muxes, single-cycle ALU, iterative MUL,
// and an IDLE/EXEC/MUL/DONE controller with registered result and flags.
module calc_stage_mc
  import calc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CONST_A = 2,
  parameter int CONST_B = 1,
  parameter int MUL_EN  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [1:0]       alu_src_a,
  input  logic [1:0]       alu_src_b,
  input  logic [3:0]       alu_op,
  input  logic             pc_src,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] alu_mux_out,
  output logic             zero,
  output logic             negative,
  output logic             carry
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   a_q, src_a, src_b, res, fin_res;
  logic               res_carry, fin_carry, is_mul, mul_go, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul = (MUL_EN != 0) && (alu_op == OP_MUL);
  assign mul_go = (state == ST_EXEC) && is_mul;

  always_comb begin
    case (alu_src_a)
      SRCA_PC:    src_a = pc_in;
      SRCA_CONST: src_a = WIDTH'(CONST_A);
      SRCA_AQ:    src_a = a_q;
      default:    src_a = imm_in;
    endcase
    case (alu_src_b)
      SRCB_BQ:    src_b = b_q;
      SRCB_CONST: src_b = WIDTH'(CONST_B);
      SRCB_IMM:   src_b = imm_in;
      default:    src_b = '0;
    endcase
  end

  // MUL and invalid opcodes both fall to the default: result 0, carry 0.
  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    case (alu_op)
      OP_ADD: {res_carry, res} = {1'b0, src_a} + {1'b0, src_b};
      OP_SUB: {res_carry, res} = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
      OP_AND: res = src_a & src_b;
      OP_OR:  res = src_a | src_b;
      OP_XOR: res = src_a ^ src_b;
      OP_SLL: res = src_a << src_b[SHW-1:0];
      OP_SRL: res = src_a >> src_b[SHW-1:0];
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: ;
    endcase
  end

  assign alu_mux_out = pc_src ? alu_out_q : res;

  assign fin_res   = (state == ST_MUL) ? mul_prod[WIDTH-1:0] : res;
  assign fin_carry = (state == ST_MUL) ? |mul_prod[2*WIDTH-1:WIDTH] : res_carry;

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_go),
    .mcand   (src_a),
    .mplier  (src_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          a_q   <= a_in;
          b_q   <= b_in;
          busy  <= 1'b1;
          state <= ST_EXEC;
        end
        ST_EXEC, ST_MUL: if ((state == ST_EXEC && !is_mul) || (state == ST_MUL && mul_done)) begin
          alu_out_q <= fin_res;
          zero      <= (fin_res == '0);
          negative  <= fin_res[WIDTH-1];
          carry     <= fin_carry;
          done      <= 1'b1;
          state     <= ST_DONE;
        end else if (state == ST_EXEC) begin
          state <= ST_MUL;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
